lcd_power_sequencer: RTL and testbench

Power-up/power-down controller for the 1024x600 LCD panel. Sequences panel VDD, the enable of the HV-mode timing generator, and the backlight in the order and with the delays the panel datasheet requires. It counts frame-start events on the generator's vsync output and detects a stalled generator. It sits between the system power-request logic and the HV-mode timing generator, and its `timing_en` output drives that generator's `en` input.

---
 rtl/lcd_pkg.sv | 70 +++++++
 rtl/lcd_seq_timer.sv | 36 +++
 rtl/lcd_power_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_lcd_power_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD panel power sequencer and the HV-mode
// timing generator: sequencer states, rail encoding and panel timing defaults.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_VDD_ON   = 3'd1,
    ST_SIG_ON   = 3'd2,
    ST_ON       = 3'd3,
    ST_BL_OFF   = 3'd4,
    ST_SIG_OFF  = 3'd5,
    ST_OFF_HOLD = 3'd6
  } seq_state_t;

  // Panel rails driven by the sequencer.
  typedef struct packed {
    logic vdd;
    logic timing;
    logic backlight;
  } rail_t;

  // 1024x600 panel timing, shared with the HV-mode generator.
  localparam int unsigned LCD_H_ACTIVE = 1024;
  localparam int unsigned LCD_V_ACTIVE = 600;
  localparam int unsigned LCD_THP      = 1344;  // clocks per line
  localparam int unsigned LCD_TVP      = 635;   // lines per frame

  // Datasheet sequencing defaults (clocks or frames).
  localparam int unsigned LCD_T_VDD_SETTLE_DEF    = 50000;
  localparam int unsigned LCD_T_SIG_FRAMES_DEF    = 10;
  localparam int unsigned LCD_T_BL_OFF_FRAMES_DEF = 5;
  localparam int unsigned LCD_T_VDD_OFF_DEF       = 20000;
  localparam int unsigned LCD_T_OFF_MIN_DEF       = 500000;
  localparam int unsigned LCD_T_FRAME_TO_DEF      = 1000000;

  // Frame watchdog budget expressed as two full frames of a given timing.
  function automatic int unsigned frame_to_clocks(input int unsigned thp,
                                                  input int unsigned tvp);
    return 2 * thp * tvp;
  endfunction

  function automatic int unsigned max6(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d,
                                       input int unsigned e, input int unsigned f);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

  // Rail pattern for each sequencer state.
  function automatic rail_t rails_for(input seq_state_t s);
    rail_t r;
    r = '0;
    case (s)
      ST_VDD_ON:  r = '{vdd: 1'b1, timing: 1'b0, backlight: 1'b0};
      ST_SIG_ON:  r = '{vdd: 1'b1, timing: 1'b1, backlight: 1'b0};
      ST_ON:      r = '{vdd: 1'b1, timing: 1'b1, backlight: 1'b1};
      ST_BL_OFF:  r = '{vdd: 1'b1, timing: 1'b1, backlight: 1'b0};
      ST_SIG_OFF: r = '{vdd: 1'b1, timing: 1'b0, backlight: 1'b0};
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Loadable down-counter shared by all timed and frame-counted sequencer states.
module lcd_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Load wins over decrement; the count never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/lcd_power_sequencer.sv
// Power-up/power-down sequencer for the 1024x600 LCD panel: orders VDD,
// timing-generator enable and backlight, and watches vsync for a stalled
// generator.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_OFF      | all rails off, waiting for power_req
//   ST_VDD_ON   | VDD up, waiting T_VDD_SETTLE clocks
//   ST_SIG_ON   | video running, counting T_SIG_FRAMES frames
//   ST_ON       | panel fully on, backlight lit
//   ST_BL_OFF   | backlight off, counting T_BL_OFF_FRAMES frames
//   ST_SIG_OFF  | video stopped, waiting T_VDD_OFF clocks before VDD off
//   ST_OFF_HOLD | VDD off, enforcing T_OFF_MIN before the next power-up
module lcd_power_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_VDD_SETTLE    = LCD_T_VDD_SETTLE_DEF,
  parameter int unsigned T_SIG_FRAMES    = LCD_T_SIG_FRAMES_DEF,
  parameter int unsigned T_BL_OFF_FRAMES = LCD_T_BL_OFF_FRAMES_DEF,
  parameter int unsigned T_VDD_OFF       = LCD_T_VDD_OFF_DEF,
  parameter int unsigned T_OFF_MIN       = LCD_T_OFF_MIN_DEF,
  parameter int unsigned T_FRAME_TO      = LCD_T_FRAME_TO_DEF,
  parameter int unsigned CNT_W           = $clog2(max6(T_VDD_SETTLE, T_SIG_FRAMES,
                                                       T_BL_OFF_FRAMES, T_VDD_OFF,
                                                       T_OFF_MIN, T_FRAME_TO)) + 1
) (
  input  logic clock,
  input  logic reset_L,
  input  logic power_req,
  input  logic vsync,
  output logic panel_vdd_en,
  output logic timing_en,
  output logic backlight_en,
  output logic ready,
  output logic busy,
  output logic fault
);

  localparam int unsigned T_MAX = max6(T_VDD_SETTLE, T_SIG_FRAMES, T_BL_OFF_FRAMES,
                                       T_VDD_OFF, T_OFF_MIN, T_FRAME_TO);

  if (T_VDD_SETTLE == 0 || T_SIG_FRAMES == 0 || T_BL_OFF_FRAMES == 0 ||
      T_VDD_OFF == 0 || T_OFF_MIN == 0 || T_FRAME_TO == 0) begin : g_zero_param
    $error("lcd_power_sequencer: all timing parameters must be nonzero");
  end

  if ($clog2(T_MAX + 1) > CNT_W) begin : g_narrow_cnt
    $error("lcd_power_sequencer: CNT_W too small for the timing parameters");
  end

  seq_state_t       state_q, state_d;
  logic             vsync_q;
  logic             frame_tick;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             wd_timeout;
  logic             fault_q, fault_d;
  rail_t            rails_q, rails_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_dec;
  logic             tmr_last;

  assign frame_tick = vsync & ~vsync_q;
  // Fires on the T_FRAME_TO-th clock since the last clear; beats a same-cycle frame tick.
  assign wd_timeout = (wd_q == CNT_W'(T_FRAME_TO - 1));

  lcd_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset_L (reset_L),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .dec_i   (tmr_dec),
    .last_o  (tmr_last)
  );

  // Next state, timer control, watchdog and registered-output decode.
  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    wd_d      = '0;
    tmr_dec   = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;

    case (state_q)
      ST_OFF: begin
        if (power_req) begin
          state_d = ST_VDD_ON;
          fault_d = 1'b0;
        end
      end
      ST_VDD_ON: begin
        tmr_dec = 1'b1;
        if (!power_req) begin
          state_d = ST_SIG_OFF;
        end else if (tmr_last) begin
          state_d = ST_SIG_ON;
        end
      end
      ST_SIG_ON: begin
        tmr_dec = frame_tick;
        wd_d    = frame_tick ? '0 : wd_q + CNT_W'(1);
        if (wd_timeout) begin
          fault_d = 1'b1;
          state_d = ST_SIG_OFF;
        end else if (!power_req) begin
          state_d = ST_SIG_OFF;
        end else if (tmr_last && frame_tick) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        wd_d = frame_tick ? '0 : wd_q + CNT_W'(1);
        if (wd_timeout) begin
          fault_d = 1'b1;
          state_d = ST_SIG_OFF;
        end else if (!power_req) begin
          state_d = ST_BL_OFF;
        end
      end
      ST_BL_OFF: begin
        tmr_dec = frame_tick;
        wd_d    = frame_tick ? '0 : wd_q + CNT_W'(1);
        if (wd_timeout) begin
          fault_d = 1'b1;
          state_d = ST_SIG_OFF;
        end else if (tmr_last && frame_tick) begin
          state_d = ST_SIG_OFF;
        end
      end
      ST_SIG_OFF: begin
        tmr_dec = 1'b1;
        if (tmr_last) state_d = ST_OFF_HOLD;
      end
      ST_OFF_HOLD: begin
        tmr_dec = 1'b1;
        if (tmr_last) state_d = ST_OFF;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Every state entry reloads the shared timer and restarts the watchdog.
    if (state_d != state_q) begin
      tmr_load = 1'b1;
      wd_d     = '0;
      case (state_d)
        ST_VDD_ON:   tmr_value = CNT_W'(T_VDD_SETTLE);
        ST_SIG_ON:   tmr_value = CNT_W'(T_SIG_FRAMES);
        ST_BL_OFF:   tmr_value = CNT_W'(T_BL_OFF_FRAMES);
        ST_SIG_OFF:  tmr_value = CNT_W'(T_VDD_OFF);
        ST_OFF_HOLD: tmr_value = CNT_W'(T_OFF_MIN);
        default:     tmr_value = '0;
      endcase
    end

    rails_d = rails_for(state_d);
    ready_d = (state_d == ST_ON);
    busy_d  = (state_d != ST_OFF) && (state_d != ST_ON);
  end

  // State, watchdog and output registers; outputs move on the same edge as the state.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_OFF;
      vsync_q <= 1'b0;
      wd_q    <= '0;
      fault_q <= 1'b0;
      rails_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      wd_q    <= wd_d;
      fault_q <= fault_d;
      rails_q <= rails_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign panel_vdd_en = rails_q.vdd;
  assign timing_en    = rails_q.timing;
  assign backlight_en = rails_q.backlight;
  assign ready        = ready_q;
  assign busy         = busy_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Directed bench for lcd_power_sequencer with short timing parameters.
module tb_lcd_power_sequencer;

  logic clock = 1'b0;
  logic reset_L = 1'b0;
  logic power_req = 1'b0;
  logic vsync = 1'b1;
  logic panel_vdd_en, timing_en, backlight_en, ready, busy, fault;

  int total = 0;
  int bad = 0;
  int rise_cnt = 0;
  int vs_cnt = 0;
  bit vs_run = 1'b1;

  lcd_power_sequencer #(
    .T_VDD_SETTLE    (10),
    .T_SIG_FRAMES    (2),
    .T_BL_OFF_FRAMES (2),
    .T_VDD_OFF       (8),
    .T_OFF_MIN       (20),
    .T_FRAME_TO      (100)
  ) dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .power_req    (power_req),
    .vsync        (vsync),
    .panel_vdd_en (panel_vdd_en),
    .timing_en    (timing_en),
    .backlight_en (backlight_en),
    .ready        (ready),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  // Timing generator model: one-cycle-low vsync every 50 clocks while enabled.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (vs_run && timing_en === 1'b1) begin
        vs_cnt++;
        if (vs_cnt == 50) begin
          vsync = 1'b0;
          vs_cnt = 0;
        end else begin
          if (vsync == 1'b0) rise_cnt++;
          vsync = 1'b1;
        end
      end else begin
        vs_cnt = 0;
        vsync = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (ready === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    power_req = 1'b0;
    tick();
    tick();
    total++;
    if ({panel_vdd_en, timing_en, backlight_en, ready, busy, fault} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 000000",
               {panel_vdd_en, timing_en, backlight_en, ready, busy, fault});
    end
    reset_L = 1'b1;
    tick();
    tick();
    total++;
    if ({panel_vdd_en, timing_en, backlight_en, ready, busy, fault} !== 6'b0) begin
      bad++;
      $display("FAIL idle_off: got %b required 000000",
               {panel_vdd_en, timing_en, backlight_en, ready, busy, fault});
    end
  endtask

  task automatic test_power_up();
    bit early, seen, bl_early;
    int base;
    power_req = 1'b1;
    tick();
    total++;
    if ({panel_vdd_en, timing_en, backlight_en, busy} !== 4'b1001) begin
      bad++;
      $display("FAIL pu_vdd: vdd/tim/bl/busy got %b required 1001",
               {panel_vdd_en, timing_en, backlight_en, busy});
    end
    early = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (timing_en !== 1'b0 || panel_vdd_en !== 1'b1) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++;
      $display("FAIL pu_settle: timing_en rose or vdd fell before cycle 11 got 1 required 0");
    end
    tick();
    total++;
    if ({panel_vdd_en, timing_en, backlight_en} !== 3'b110) begin
      bad++;
      $display("FAIL pu_timing_on: vdd/tim/bl got %b required 110",
               {panel_vdd_en, timing_en, backlight_en});
    end
    base = rise_cnt;
    seen = 1'b0;
    bl_early = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (rise_cnt == base + 2) seen = 1'b1;
      else if (backlight_en !== 1'b0) bl_early = 1'b1;
    end
    total++;
    if (!seen || bl_early) begin
      bad++;
      $display("FAIL pu_frames: seen=%0b bl_early=%0b required seen=1 bl_early=0", seen, bl_early);
    end
    total++;
    if ({backlight_en, ready, busy, fault} !== 4'b1100) begin
      bad++;
      $display("FAIL pu_on: bl/ready/busy/fault got %b required 1100",
               {backlight_en, ready, busy, fault});
    end
  endtask

  task automatic test_power_down(input bit rereq);
    bit seen, err;
    int base;
    power_req = 1'b0;
    tick();
    total++;
    if ({panel_vdd_en, timing_en, backlight_en, ready, busy} !== 5'b11001) begin
      bad++;
      $display("FAIL pd_bl_off: vdd/tim/bl/ready/busy got %b required 11001",
               {panel_vdd_en, timing_en, backlight_en, ready, busy});
    end
    if (rereq) power_req = 1'b1;
    base = rise_cnt;
    seen = 1'b0;
    err = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (rise_cnt == base + 2) seen = 1'b1;
      else if (timing_en !== 1'b1 || backlight_en !== 1'b0) err = 1'b1;
    end
    total++;
    if (!seen || err || {panel_vdd_en, timing_en, backlight_en} !== 3'b100) begin
      bad++;
      $display("FAIL pd_sig_off: seen=%0b err=%0b vdd/tim/bl=%b required 1 0 100",
               seen, err, {panel_vdd_en, timing_en, backlight_en});
    end
    err = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (panel_vdd_en !== 1'b1) err = 1'b1;
    end
    tick();
    total++;
    if (err || panel_vdd_en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pd_vdd_off: early=%0b vdd=%b busy=%b required 0 0 1", err, panel_vdd_en, busy);
    end
    err = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (busy !== 1'b1 || panel_vdd_en !== 1'b0) err = 1'b1;
    end
    tick();
    total++;
    if (err || busy !== 1'b0 || panel_vdd_en !== 1'b0) begin
      bad++;
      $display("FAIL pd_off: hold_err=%0b busy=%b vdd=%b required 0 0 0", err, busy, panel_vdd_en);
    end
    if (rereq) begin
      tick();
      total++;
      if (panel_vdd_en !== 1'b1 || busy !== 1'b1 || timing_en !== 1'b0) begin
        bad++;
        $display("FAIL rereq_vdd_on: vdd=%b busy=%b tim=%b required 1 1 0",
                 panel_vdd_en, busy, timing_en);
      end
      err = 1'b0;
      for (int i = 1; i <= 9; i++) begin
        tick();
        if (timing_en !== 1'b0) err = 1'b1;
      end
      tick();
      total++;
      if (err || timing_en !== 1'b1) begin
        bad++;
        $display("FAIL rereq_timing: early=%0b tim=%b required 0 1", err, timing_en);
      end
      wait_ready(seen);
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL rereq_ready: ready got 0 required 1 within 400 clocks");
      end
    end
  endtask

  task automatic test_abort();
    bit err;
    power_req = 1'b1;
    tick();
    for (int i = 2; i <= 5; i++) tick();
    power_req = 1'b0;
    tick();
    total++;
    if ({panel_vdd_en, timing_en, backlight_en, busy} !== 4'b1001) begin
      bad++;
      $display("FAIL abort_sig_off: vdd/tim/bl/busy got %b required 1001",
               {panel_vdd_en, timing_en, backlight_en, busy});
    end
    err = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (panel_vdd_en !== 1'b1 || timing_en !== 1'b0) err = 1'b1;
    end
    tick();
    total++;
    if (err || panel_vdd_en !== 1'b0 || timing_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_vdd_off: err=%0b vdd=%b tim=%b required 0 0 0", err, panel_vdd_en, timing_en);
    end
    err = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (busy !== 1'b1) err = 1'b1;
    end
    tick();
    total++;
    if (err || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_off: hold_err=%0b busy=%b required 0 0", err, busy);
    end
  endtask

  task automatic test_stall();
    bit seen, err;
    int base;
    base = rise_cnt;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (rise_cnt != base) seen = 1'b1;
    end
    vs_run = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL stall_sync: no frame seen got 0 required 1");
    end
    err = 1'b0;
    for (int i = 1; i <= 99; i++) begin
      tick();
      if (fault !== 1'b0 || backlight_en !== 1'b1) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL stall_early: fault or backlight changed before 100 clocks got 1 required 0");
    end
    tick();
    total++;
    if ({fault, panel_vdd_en, timing_en, backlight_en, ready} !== 5'b11000) begin
      bad++;
      $display("FAIL stall_fault: fault/vdd/tim/bl/ready got %b required 11000",
               {fault, panel_vdd_en, timing_en, backlight_en, ready});
    end
    for (int i = 1; i <= 7; i++) tick();
    tick();
    total++;
    if (panel_vdd_en !== 1'b0 || fault !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_vdd_off: vdd=%b fault=%b busy=%b required 0 1 1", panel_vdd_en, fault, busy);
    end
    for (int i = 1; i <= 19; i++) tick();
    tick();
    total++;
    if (busy !== 1'b0 || fault !== 1'b1 || panel_vdd_en !== 1'b0) begin
      bad++;
      $display("FAIL stall_off: busy=%b fault=%b vdd=%b required 0 1 0", busy, fault, panel_vdd_en);
    end
    vs_run = 1'b1;
    tick();
    total++;
    if (panel_vdd_en !== 1'b1 || fault !== 1'b0) begin
      bad++;
      $display("FAIL stall_fault_clear: vdd=%b fault=%b required 1 0", panel_vdd_en, fault);
    end
    wait_ready(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL stall_recover: ready got 0 required 1 within 400 clocks");
    end
  endtask

  task automatic test_reset_mid();
    bit err;
    reset_L = 1'b0;
    #1;
    total++;
    if ({panel_vdd_en, timing_en, backlight_en, ready, busy, fault} !== 6'b0) begin
      bad++;
      $display("FAIL rst_async: got %b required 000000",
               {panel_vdd_en, timing_en, backlight_en, ready, busy, fault});
    end
    tick();
    tick();
    reset_L = 1'b1;
    total++;
    if ({panel_vdd_en, timing_en, backlight_en, ready, busy, fault} !== 6'b0) begin
      bad++;
      $display("FAIL rst_held: got %b required 000000",
               {panel_vdd_en, timing_en, backlight_en, ready, busy, fault});
    end
    tick();
    total++;
    if ({panel_vdd_en, timing_en, backlight_en, busy} !== 4'b1001) begin
      bad++;
      $display("FAIL rst_reseq_vdd: vdd/tim/bl/busy got %b required 1001",
               {panel_vdd_en, timing_en, backlight_en, busy});
    end
    err = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (timing_en !== 1'b0) err = 1'b1;
    end
    tick();
    total++;
    if (err || timing_en !== 1'b1) begin
      bad++;
      $display("FAIL rst_reseq_timing: early=%0b tim=%b required 0 1", err, timing_en);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down(1'b0);
    test_abort();
    test_power_up();
    test_power_down(1'b1);
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
